// File: rtl/mem_pkg.sv
// Shared defaults and controller state encoding for the synchronous-write RAM.
package mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage : mem_pkg

// File: rtl/ram_core.sv
// Storage array with one synchronous write port and one registered read port.
module ram_core
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_comb rdata_d = mem_q[raddr];

  // NOTE: the array has no reset so it maps onto plain RAM; zeroing is done by the controller's clear sequence.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // NOTE: non-blocking updates mean a same-edge read of the written entry still sees the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : ram_core

// File: rtl/ram_syncwrite.sv
// RAM controller: self-clearing after reset or clr, explicit or burst-pointer writes,
// one-cycle-latency reads and a done pulse on burst pointer wrap.
module ram_syncwrite
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_burst,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ptr_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        if (clr) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == LAST_IDX) begin
          clr_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        // A clear request wins over any write presented in the same cycle.
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          ptr_d     = '0;
        end else if (wr_valid) begin
          mem_we    = 1'b1;
          mem_wdata = wr_data;
          if (wr_burst) begin
            mem_waddr = ptr_q;
            ptr_d     = ptr_q + 1'b1;
            done_d    = (ptr_q == LAST_IDX);
          end else begin
            mem_waddr = wr_addr;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign wr_ready = (state_q == ST_IDLE);
  assign done     = done_q;

  ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(rd_addr),
    .rdata(dout)
  );

endmodule : ram_syncwrite

// File: tb/tb_ram_syncwrite.sv
// Directed self-checking bench for ram_syncwrite with hand-computed expectations.
module tb_ram_syncwrite;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_burst;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] dout;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_syncwrite #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_burst(wr_burst),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .dout    (dout),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic burst, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    wr_valid = 1'b1;
    wr_burst = burst;
    wr_addr  = addr;
    wr_data  = data;
    step();
    wr_valid = 1'b0;
    wr_burst = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
    rd_addr = addr;
    step();
    check(tag, dout, exp);
  endtask

  task automatic expect_clear(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_nrdy"}, wr_ready, 0);
      step();
    end
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_rdy"}, wr_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    clr      = 1'b0;
    wr_valid = 1'b0;
    wr_burst = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    step();
    step();
    check("rst_busy", busy, 1);
    check("rst_rdy", wr_ready, 0);
    check("rst_dout", dout, 0);
    check("rst_done", done, 0);

    // Reset release: four clear cycles, then memory reads all zero.
    rst = 1'b0;
    expect_clear("init");
    for (int a = 0; a < 4; a++) rd_check("init_rd", 2'(a), 8'h00);

    // Explicit writes.
    wr(1'b0, 2'd0, 8'h2F);
    wr(1'b0, 2'd2, 8'hEF);
    rd_check("expl_rd0", 2'd0, 8'h2F);
    rd_check("expl_rd2", 2'd2, 8'hEF);

    // Burst writes with wrap; done pulses only after the fourth.
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_burst = 1'b1;
      wr_data  = 8'(8'h11 * (i + 1));
      step();
      check("burst_done", done, (i == 3) ? 1 : 0);
    end
    wr_valid = 1'b0;
    wr_burst = 1'b0;
    step();
    check("burst_done_clr", done, 0);
    rd_check("burst_rd0", 2'd0, 8'h11);
    rd_check("burst_rd1", 2'd1, 8'h22);
    rd_check("burst_rd2", 2'd2, 8'h33);
    rd_check("burst_rd3", 2'd3, 8'h44);
    wr(1'b1, 2'd3, 8'h55);
    check("burst5_done", done, 0);
    rd_check("burst5_rd0", 2'd0, 8'h55);
    rd_check("burst5_rd1", 2'd1, 8'h22);

    // Read-during-write returns old data first.
    wr(1'b0, 2'd1, 8'h20);
    rd_addr  = 2'd1;
    wr_valid = 1'b1;
    wr_addr  = 2'd1;
    wr_data  = 8'hFF;
    step();
    wr_valid = 1'b0;
    check("rdw_old", dout, 8'h20);
    step();
    check("rdw_new", dout, 8'hFF);

    // clr with a simultaneous write: write dropped, pointer rewinds.
    clr      = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 2'd3;
    wr_data  = 8'hAA;
    step();
    clr      = 1'b0;
    wr_valid = 1'b0;
    rd_addr  = 2'd3;
    check("clr_busy0", busy, 1);
    step();
    check("clr_drop_rd3", dout, 8'h44);
    check("clr_busy1", busy, 1);
    step();
    check("clr_busy2", busy, 1);
    step();
    check("clr_busy3", busy, 1);
    step();
    check("clr_idle", busy, 0);
    check("clr_rdy", wr_ready, 1);
    for (int a = 0; a < 4; a++) rd_check("clr_rd", 2'(a), 8'h00);
    wr(1'b1, 2'd3, 8'h66);
    rd_check("clr_ptr_rd0", 2'd0, 8'h66);
    rd_check("clr_ptr_rd1", 2'd1, 8'h00);

    // clr during CLEAR restarts the clear count.
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    expect_clear("reclr");

    // rst in the middle of a burst.
    wr(1'b1, 2'd0, 8'h77);
    wr(1'b1, 2'd0, 8'h88);
    rd_addr = 2'd0;
    step();
    check("mid_pre_rd0", dout, 8'h77);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1);
    check("mid_rst_rdy", wr_ready, 0);
    check("mid_rst_dout", dout, 0);
    step();
    rst = 1'b0;
    expect_clear("mid");
    wr(1'b1, 2'd3, 8'h99);
    rd_check("mid_rd0", 2'd0, 8'h99);
    rd_check("mid_rd1", 2'd1, 8'h00);
    rd_check("mid_rd2", 2'd2, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ram_syncwrite
